// File: rtl/rng_pkg.sv
// -----------------------------------------------------------------------------
// rng_pkg
// Shared types and constants for the Lab1 random-number roll controller.
//   DATA_W       : width of the LFSR value and of the display path
//   roll_state_t : controller states (idle, rolling, settling, done)
//   sat_add      : saturating gap arithmetic helper
// -----------------------------------------------------------------------------
package rng_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLL,
    S_SETTLE,
    S_DONE
  } roll_state_t;

  // Gap growth clamps at the ceiling instead of wrapping, so the cadence
  // settles at a steady slow rate rather than suddenly speeding up again.
  function automatic int sat_add(input int value, input int inc, input int ceiling);
    int sum;
    sum = value + inc;
    return (sum > ceiling) ? ceiling : sum;
  endfunction

endpackage

// File: rtl/rng_edge_det.sv
// -----------------------------------------------------------------------------
// rng_edge_det
// Registers a debounced key level once and flags its rising edge. Holding the
// key for any number of cycles yields a single one-cycle rise.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_in    : debounced key level
//   o_rise  : high in the cycle where i_in is 1 and was 0 on the previous edge
// -----------------------------------------------------------------------------
module rng_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_rise
);

  logic in_d_q;

  // NOTE: state elements use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_d_q <= 1'b0;
    end else begin
      in_d_q <= i_in;
    end
  end

  assign o_rise = i_in & ~in_d_q;

endmodule

// File: rtl/rng_roll_ctrl.sv
// -----------------------------------------------------------------------------
// rng_roll_ctrl
// Sequencing controller for the 4-bit random-number datapath. After a start
// key press it pulses the LFSR step strobe with a decelerating cadence
// (gaps 1,2,3,... saturating at MAX_GAP), freezes the result on a stop key
// press, and keeps the current and previous results for the display.
//
// Build option:
//   RNG_AUTO_STOP_EN : when defined, the step issued at the saturated gap also
//                      ends the roll (auto-stop). When undefined, rolling
//                      continues every MAX_GAP cycles until a stop press.
//
// Ports:
//   i_clk       : system clock
//   i_rst_n     : asynchronous active-low reset
//   i_start     : start key level (rising edge starts a roll in IDLE/DONE)
//   i_stop      : stop key level (rising edge ends a roll in ROLL)
//   i_show      : while high in IDLE/DONE, display the previous result
//   i_rand      : current LFSR value
//   o_lfsr_step : one-cycle pulse; the LFSR advances on the next edge
//   o_display   : registered value for the seven-segment path
//   o_busy      : high in ROLL or SETTLE
//   o_done      : one-cycle pulse in the cycle a result is captured
// -----------------------------------------------------------------------------
module rng_roll_ctrl
  import rng_pkg::*;
#(
  parameter int INIT_GAP = 1,
  parameter int GAP_INC  = 1,
  parameter int MAX_GAP  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_show,
  input  logic [DATA_W-1:0] i_rand,
  output logic              o_lfsr_step,
  output logic [DATA_W-1:0] o_display,
  output logic              o_busy,
  output logic              o_done
);

  localparam int GAP_W = $clog2(MAX_GAP + 1);

  roll_state_t       state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] display_q, display_d;

  logic start_rise;
  logic stop_rise;
  logic step_due;
  logic busy;

  rng_edge_det u_start_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_in    (i_start),
    .o_rise  (start_rise)
  );

  rng_edge_det u_stop_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_in    (i_stop),
    .o_rise  (stop_rise)
  );

  // The step falls on the last cycle of each gap, so with gap==1 and a
  // zeroed counter the very first ROLL cycle already steps.
  assign step_due = (gap_cnt_q == gap_q - GAP_W'(1));
  assign busy     = (state_q == S_ROLL) || (state_q == S_SETTLE);

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    o_lfsr_step = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Start wins over a simultaneous stop here; stop alone is ignored.
        if (start_rise) begin
          state_d   = S_ROLL;
          gap_d     = GAP_W'(INIT_GAP);
          gap_cnt_d = '0;
        end
      end

      S_ROLL: begin
        // Stop beats a due step so the LFSR is frozen before capture.
        if (stop_rise) begin
          state_d = S_SETTLE;
        end else if (step_due) begin
          o_lfsr_step = 1'b1;
          gap_cnt_d   = '0;
          gap_d       = GAP_W'(sat_add(int'(gap_q), GAP_INC, MAX_GAP));
`ifdef RNG_AUTO_STOP_EN
          // The step at the saturated gap is the last one; the capture in
          // SETTLE then sees the post-step LFSR value.
          if (int'(gap_q) == MAX_GAP) begin
            state_d = S_SETTLE;
          end
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      S_SETTLE: begin
        prev_d  = cur_q;
        cur_d   = i_rand;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // While rolling the display follows the LFSR; i_show only matters at rest.
  always_comb begin
    display_d = i_show ? prev_q : cur_q;
    if (busy) begin
      display_d = i_rand;
    end
  end

  // NOTE: the result registers are reset too, because a reset must wipe
  // the shown result back to zero, not just restart the sequencer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      gap_q     <= GAP_W'(INIT_GAP);
      gap_cnt_q <= '0;
      cur_q     <= '0;
      prev_q    <= '0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      display_q <= display_d;
    end
  end

  assign o_display = display_q;
  assign o_busy    = busy;
  assign o_done    = (state_q == S_SETTLE);

endmodule

// File: tb/tb_rng_roll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rng_roll_ctrl
// Self-checking bench for rng_roll_ctrl with default parameters
// (INIT_GAP=1, GAP_INC=1, MAX_GAP=8). Honours RNG_AUTO_STOP_EN if defined.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 3 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_rng_roll_ctrl;
  import rng_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              show;
  logic [DATA_W-1:0] rnd;
  logic              step;
  logic [DATA_W-1:0] disp;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rng_roll_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_show      (show),
    .i_rand      (rnd),
    .o_lfsr_step (step),
    .o_display   (disp),
    .o_busy      (busy),
    .o_done      (done)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       show;
    logic [3:0] rnd;
    logic       exp_step;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_disp;
  } vec_t;

  vec_t vecs[14];
  int   exp_q[$];
  int   step_list[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    show  = 1'b0;
    rnd   = '0;

    // ---------------- Reset state ----------------
    #3;
    check("reset step", step, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset disp", disp, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // ---------------- Table: short run A (result 0x9) ----------------
    // Each row is one cycle: inputs driven, then outputs checked.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0}; // IDLE, start rise
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0}; // ROLL c0, step
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 4'h2}; // c1
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 4'h3}; // c2, step
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 4'h4}; // c3
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, 4'h5}; // c4
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 4'h6}; // c5 due, stop wins
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 1'b1, 1'b1, 4'h7}; // SETTLE, capture 9
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h9}; // DONE
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h9}; // show, 1-cycle latency
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0}; // prev = 0
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h0}; // release, latency
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h9}; // stop rise in DONE
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 4'h9}; // ignored
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      start = vecs[i].start;
      stop  = vecs[i].stop;
      show  = vecs[i].show;
      rnd   = vecs[i].rnd;
      settle();
      check($sformatf("vec%0d step", i), step, vecs[i].exp_step);
      check($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d done", i), done, vecs[i].exp_done);
      check($sformatf("vec%0d disp", i), disp, vecs[i].exp_disp);
    end

    // ---------------- Run B (result 0x3), then show held 50 cycles ----------------
    next_cycle(); start = 1'b1; rnd = 4'h5;
    next_cycle(); start = 1'b0;                 // ROLL c0
    next_cycle(); stop  = 1'b1;                 // ROLL c1, stop rise
    next_cycle(); stop  = 1'b0; rnd = 4'h3;     // SETTLE
    settle();
    check("runB done", done, 1);
    next_cycle(); rnd = 4'h7;                   // DONE
    settle();
    check("runB disp", disp, 4'h3);
    check("runB done clear", done, 0);
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      show = 1'b1;
      settle();
      check($sformatf("show%0d disp", i), disp, (i == 0) ? 4'h3 : 4'h9);
    end
    next_cycle(); show = 1'b0; settle();
    check("show release latency", disp, 4'h9);
    next_cycle(); settle();
    check("show released disp", disp, 4'h3);

    // ---------------- Cadence run with scoreboard ----------------
    step_list = '{0, 2, 5, 9, 14, 20, 27, 35, 43, 51};
    next_cycle();
    start = 1'b1;
`ifdef RNG_AUTO_STOP_EN
    foreach (step_list[k]) if (step_list[k] <= 35) exp_q.push_back(step_list[k]);
    for (int c = 0; c < 36; c++) begin
`else
    foreach (step_list[k]) exp_q.push_back(step_list[k]);
    for (int c = 0; c < 53; c++) begin
`endif
      next_cycle();
      start = (c == 0);                         // start held two cycles in total
      rnd   = DATA_W'(c);
      settle();
      check($sformatf("cad c%0d busy", c), busy, 1);
      if (step) begin
        if (exp_q.size() == 0) check($sformatf("cad extra step c%0d", c), 1, 0);
        else check("cad step cycle", c, exp_q.pop_front());
      end
    end
    check("cad missing steps", exp_q.size(), 0);
`ifdef RNG_AUTO_STOP_EN
    next_cycle(); settle();                     // auto-stop SETTLE
    check("auto settle done", done, 1);
    check("auto settle step", step, 0);
`else
    next_cycle(); stop = 1'b1; settle();        // c53, no step due
    check("cad c53 step", step, 0);
    check("cad c53 busy", busy, 1);
    next_cycle(); stop = 1'b0; settle();        // SETTLE
    check("cad settle done", done, 1);
`endif
    next_cycle(); settle();
    check("cad after busy", busy, 0);
    check("cad after done", done, 0);

    // ---------------- Simultaneous start + stop ----------------
    next_cycle(); start = 1'b1; stop = 1'b1; settle();
    check("both idle busy", busy, 0);
    next_cycle(); settle();                     // ROLL c0 (start won)
    check("both idle -> roll busy", busy, 1);
    check("both idle -> roll step", step, 1);
    next_cycle(); start = 1'b0; stop = 1'b0; settle();
    check("both roll c1 step", step, 0);
    next_cycle(); start = 1'b1; stop = 1'b1; settle();   // c2 due, stop wins
    check("both roll step", step, 0);
    next_cycle(); settle();
    check("both roll -> settle done", done, 1);
    next_cycle(); start = 1'b0; stop = 1'b0; settle();
    check("both settle -> done busy", busy, 0);

    // ---------------- Asynchronous reset mid-roll ----------------
    next_cycle(); start = 1'b1; rnd = 4'hA;
    next_cycle(); start = 1'b0; rnd = 4'hB;     // c0
    next_cycle(); rnd = 4'hC;                   // c1
    next_cycle(); rnd = 4'hD; settle();         // c2, step due
    check("pre-reset step", step, 1);
    check("pre-reset disp", disp, 4'hC);
    #1 rst_n = 1'b0;
    #1;
    check("async rst step", step, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst disp", disp, 0);
    #1 rst_n = 1'b1;
    next_cycle(); settle();
    check("post rst busy", busy, 0);
    check("post rst disp", disp, 0);
    next_cycle(); show = 1'b1;
    next_cycle(); settle();
    check("post rst prev lost", disp, 0);
    show = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
